lcd_bus_decoder: RTL and testbench
==================================

# lcd_bus_decoder

Receive-side decoder for the HD44780-style 4-bit LCD bus that the LCD driver produces on the Spartan-3E kit. It watches lcd_rs/lcd_rw/lcd_e/lcd_4..lcd_7 and follows the controller's init sequence. It assembles nibbles into bytes, executes the display commands, and keeps a 2x16 shadow of the visible DDRAM. The shadow is presented as a 256-bit `chars` vector with the same packing the top level uses, for on-chip mirroring and self-checking benches.

## Interface
Parameters:
- BUSY_CYCLES, 2000, busy time after a normal command or data write (40 us at 50 MHz); used only with the busy feature.
- CLEAR_CYCLES, 82000, busy time after clear/home (1.64 ms); used only with the busy feature.

Ports:
- clk  in  1  system clock; all bus inputs come from the same domain.
- reset  in  1  synchronous, active-high.
- lcd_rs, lcd_rw, lcd_e  in  1 each  bus control as driven by the LCD driver.
- lcd_4, lcd_5, lcd_6, lcd_7  in  1 each  data nibble, DB4..DB7.
- chars  out  256  shadow text; character i (0..15 line 1, 16..31 line 2) at chars[255-8i -: 8].
- display_on  out  1  display-control D bit.
- ac  out  7  DDRAM address counter.
- four_bit  out  1  4-bit mode entered.
- byte_stb  out  1  one-cycle pulse when a full byte is decoded.
- byte_rs  out  1  RS of the last byte.
- byte_val  out  8  value of the last byte.
- lcd_db_o  out  4  read-data nibble (LCD_DEC_BUSY_EN only).
- lcd_db_oe  out  1  read-data enable (LCD_DEC_BUSY_EN only).

## Operation
- Bus sampling:
  - All bus inputs are registered once.
  - A transfer occurs on a falling edge of lcd_e, detected as e_q=1 and e=0. RS, RW and the nibble are the values registered in that cycle.
- Reset values:
  - chars all 0x20; ac=0; I/D=1; display_on=0; four_bit=0.
  - byte_stb=0, byte_rs=0, byte_val=0; lcd_db_oe=0; nibble phase=HIGH; cgram_sel=0; busy=0.
- States:
  - INIT (8-bit): each edge is one full byte {nibble,4'h0}.
    - 0x3X is a no-op and stays in INIT.
    - 0x2X sets four_bit=1 and goes to NIB_HI.
    - Any other byte in INIT is ignored.
  - NIB_HI: latch the high nibble and go to NIB_LO.
  - NIB_LO: form the byte, pulse byte_stb, execute it, return to NIB_HI.
- Commands (RS=0, RW=0):
  - 0x01 clear: all 32 chars=0x20; ac=0; I/D=1.
  - 0x02/0x03 home: ac=0.
  - 0x04–0x07 entry mode: I/D=bit1; the shift bit is ignored.
  - 0x08–0x0F: display_on=bit2.
  - 0x10–0x1F: if bit3=0, ac steps +1 if bit2=1, else −1. Display shift is ignored.
  - 0x20–0x3F function set: ignored in 4-bit mode.
  - 0x40–0x7F CGRAM address: cgram_sel=1.
  - 0x80–0xFF: ac=byte[6:0]; cgram_sel=0.
- Data write (RS=1, RW=0):
  - If cgram_sel=1, the byte is discarded.
  - Otherwise, ac 0x00–0x0F writes char ac, and 0x40–0x4F writes char 16+(ac−0x40).
  - Other addresses are held nowhere visible, but ac still steps.
- ac stepping follows HD44780 2-line wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Addresses 0x28–0x3F and 0x68–0x7F set directly are held; the next step continues from them modulo 128.
- Reads (RW=1):
  - Reads never modify chars.
  - In 4-bit mode they consume two edges like writes.
  - A data read (RS=1) steps ac once after the low nibble.

## Timing
- Minimum lcd_e high and low time: 1 clk each.
- Edge-detect cycle N → at N+1: chars/ac/display_on updated, byte_stb high for exactly one cycle.
- Clear updates all 32 characters in that same single cycle.
- Reset asserted mid-byte discards the held high nibble and returns to INIT.
- RS/RW differing between the two nibbles of a byte: the low-nibble values govern.

## Configuration
- LCD_DEC_BUSY_EN defined:
  - lcd_db_o/lcd_db_oe exist.
  - The busy counter loads CLEAR_CYCLES after clear/home, and BUSY_CYCLES after every other write in 4-bit mode.
  - During a read with lcd_e high, lcd_db_oe=1:
    - RS=0: high phase drives {BF, ac[6:4]}, low phase drives ac[3:0].
    - RS=1: drives the high/low nibble of char at ac, or 0x20 if ac is not visible.
  - Writes during busy are still executed; the bench flags them.
- LCD_DEC_BUSY_EN undefined:
  - Both ports absent, no counter, reads are pure no-ops apart from the ac step.

## Structure
- Package lcd_dec_pkg holds:
  - command opcode masks/values;
  - DDRAM visible ranges and wrap limits (0x27, 0x40, 0x67);
  - SPACE=8'h20;
  - the state enum INIT/NIB_HI/NIB_LO.
- Sub-module lcd_nibble_assembler handles input registering, falling-edge detect, INIT/4-bit nibble pairing and byte_stb. The parent holds command execution, ac and the chars shadow.

## Test plan
- Reset, then INIT edges 0x3,0x3,0x3,0x2 → four_bit=1 after the 4th edge; chars all 0x20; display_on=0.
- Commands 0x0C, 0x80, then data "Minh" → display_on=1; chars[255:224]="Minh"; ac=0x04.
- Command 0xC0, then data "2003" → chars[127:96]="2003"; ac=0x44.
- ac=0x27 then data 0x41 → no visible char changes; ac=0x40. Then command 0x04 (I/D=0) and data 0x42 at 0x40 → char 16=0x42; ac=0x27.
- Command 0x01 after filled lines → all chars=0x20; ac=0 at edge+1. Reset asserted between the two nibbles → state INIT; four_bit=0.
- (LCD_DEC_BUSY_EN) Read with RS=0 immediately after 0x01 → first nibble 4'b1000 (BF=1, ac=0). Read after CLEAR_CYCLES → 4'b0000.

Source files
------------

// File: rtl/lcd_dec_pkg.sv
// Shared constants, state enum and address helpers for the HD44780 4-bit bus decoder.
package lcd_dec_pkg;

  typedef enum logic [1:0] {INIT, NIB_HI, NIB_LO} dec_state_e;

  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [3:0] INIT_4BIT_NIB = 4'h2;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_DISP_MASK  = 8'hF8;
  localparam logic [7:0] CMD_DISP       = 8'h08;
  localparam logic [7:0] CMD_SHIFT_MASK = 8'hF0;
  localparam logic [7:0] CMD_SHIFT      = 8'h10;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
  localparam logic [7:0] CMD_FUNC       = 8'h20;
  localparam logic [7:0] CMD_CGRAM_MASK = 8'hC0;
  localparam logic [7:0] CMD_CGRAM      = 8'h40;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_DDRAM      = 8'h80;

  localparam logic [6:0] AC_L1_START = 7'h00;
  localparam logic [6:0] AC_L1_END   = 7'h27;
  localparam logic [6:0] AC_L2_START = 7'h40;
  localparam logic [6:0] AC_L2_END   = 7'h67;

  // Visible windows are 0x00-0x0F and 0x40-0x4F: bits [5:4] clear in both.
  function automatic logic ac_visible(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic logic [4:0] ac_char_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Two-line DDRAM wrap: line 1 ends at 0x27, line 2 at 0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == AC_L1_END) return AC_L2_START;
      if (a == AC_L2_END) return AC_L1_START;
      return a + 7'd1;
    end
    if (a == AC_L1_START) return AC_L2_END;
    if (a == AC_L2_START) return AC_L1_END;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_nibble_assembler.sv
// Registers the LCD bus, detects falling lcd_e and pairs nibbles into bytes after the
// 8-bit init phase. Extra bus taps exist only with LCD_DEC_BUSY_EN.
module lcd_nibble_assembler
  import lcd_dec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [3:0] lcd_nib,
  output logic       four_bit,
  output logic       byte_stb,
  output logic       byte_rs,
  output logic [7:0] byte_val,
  output logic       exec_c,
  output logic       exec_rs_c,
  output logic       exec_rw_c,
  output logic [7:0] exec_val_c
`ifdef LCD_DEC_BUSY_EN
  ,
  output logic       bus_e,
  output logic       bus_rs,
  output logic       bus_rw,
  output logic       phase_lo
`endif
);

  dec_state_e state_q, state_d;
  logic       rs_q, rw_q, e_q, e_prev_q;
  logic [3:0] nib_q, hi_q, hi_d;
  logic       four_bit_q, four_bit_d;
  logic       byte_stb_q, byte_rs_q;
  logic [7:0] byte_val_q;
  logic       edge_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      e_prev_q   <= 1'b0;
      nib_q      <= 4'h0;
      hi_q       <= 4'h0;
      four_bit_q <= 1'b0;
      byte_stb_q <= 1'b0;
      byte_rs_q  <= 1'b0;
      byte_val_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      rs_q       <= lcd_rs;
      rw_q       <= lcd_rw;
      e_q        <= lcd_e;
      e_prev_q   <= e_q;
      nib_q      <= lcd_nib;
      hi_q       <= hi_d;
      four_bit_q <= four_bit_d;
      byte_stb_q <= exec_c;
      if (exec_c) begin
        byte_rs_q  <= exec_rs_c;
        byte_val_q <= exec_val_c;
      end
    end
  end

  assign edge_c = e_prev_q & ~e_q;

  // Next state; exec_c marks the cycle a complete byte is handed to the parent.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    four_bit_d = four_bit_q;
    exec_c     = 1'b0;
    exec_rs_c  = rs_q;
    exec_rw_c  = rw_q;
    exec_val_c = {hi_q, nib_q};
    case (state_q)
      INIT: begin
        if (edge_c && nib_q == INIT_4BIT_NIB) begin
          four_bit_d = 1'b1;
          state_d    = NIB_HI;
        end
      end
      NIB_HI: begin
        if (edge_c) begin
          hi_d    = nib_q;
          state_d = NIB_LO;
        end
      end
      NIB_LO: begin
        if (edge_c) begin
          exec_c  = 1'b1;
          state_d = NIB_HI;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign four_bit = four_bit_q;
  assign byte_stb = byte_stb_q;
  assign byte_rs  = byte_rs_q;
  assign byte_val = byte_val_q;

`ifdef LCD_DEC_BUSY_EN
  assign bus_e    = e_q;
  assign bus_rs   = rs_q;
  assign bus_rw   = rw_q;
  assign phase_lo = (state_q == NIB_LO);
`endif

endmodule

// File: rtl/lcd_bus_decoder.sv
// HD44780 4-bit bus receiver keeping a 2x16 DDRAM shadow. Define LCD_DEC_BUSY_EN to add
// the busy counter and the read-back drivers lcd_db_o/lcd_db_oe.
module lcd_bus_decoder
  import lcd_dec_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic         lcd_4,
  input  logic         lcd_5,
  input  logic         lcd_6,
  input  logic         lcd_7,
  output logic [255:0] chars,
  output logic         display_on,
  output logic [6:0]   ac,
  output logic         four_bit,
  output logic         byte_stb,
  output logic         byte_rs,
  output logic [7:0]   byte_val
`ifdef LCD_DEC_BUSY_EN
  ,
  output logic [3:0]   lcd_db_o,
  output logic         lcd_db_oe
`endif
);

  if (BUSY_CYCLES == 0 || CLEAR_CYCLES < BUSY_CYCLES) begin : g_bad_cfg
    $error("lcd_bus_decoder: CLEAR_CYCLES must be >= BUSY_CYCLES > 0");
  end

  logic       exec_c, exec_rs_c, exec_rw_c;
  logic [7:0] exec_val_c;

  logic [255:0] chars_q, chars_d;
  logic [6:0]   ac_q, ac_d;
  logic         id_q, id_d;
  logic         disp_q, disp_d;
  logic         cgram_q, cgram_d;

`ifdef LCD_DEC_BUSY_EN
  localparam int unsigned BUSY_W = $clog2(CLEAR_CYCLES + 1);
  logic              bus_e, bus_rs, bus_rw, phase_lo;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [3:0]        db_q, db_d;
  logic              db_oe_q, db_oe_d;
  logic [7:0]        rd_char_c;
`endif

  lcd_nibble_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_nib    ({lcd_7, lcd_6, lcd_5, lcd_4}),
    .four_bit   (four_bit),
    .byte_stb   (byte_stb),
    .byte_rs    (byte_rs),
    .byte_val   (byte_val),
    .exec_c     (exec_c),
    .exec_rs_c  (exec_rs_c),
    .exec_rw_c  (exec_rw_c),
    .exec_val_c (exec_val_c)
`ifdef LCD_DEC_BUSY_EN
    ,
    .bus_e      (bus_e),
    .bus_rs     (bus_rs),
    .bus_rw     (bus_rw),
    .phase_lo   (phase_lo)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      chars_q <= {32{SPACE}};
      ac_q    <= 7'h00;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      cgram_q <= 1'b0;
`ifdef LCD_DEC_BUSY_EN
      busy_q  <= '0;
      db_q    <= 4'h0;
      db_oe_q <= 1'b0;
`endif
    end else begin
      chars_q <= chars_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      cgram_q <= cgram_d;
`ifdef LCD_DEC_BUSY_EN
      busy_q  <= busy_d;
      db_q    <= db_d;
      db_oe_q <= db_oe_d;
`endif
    end
  end

  // Command and data execution on each decoded byte.
  always_comb begin
    chars_d = chars_q;
    ac_d    = ac_q;
    id_d    = id_q;
    disp_d  = disp_q;
    cgram_d = cgram_q;
    if (exec_c && !exec_rw_c && !exec_rs_c) begin
      if ((exec_val_c & CMD_DDRAM_MASK) == CMD_DDRAM) begin
        ac_d    = exec_val_c[6:0];
        cgram_d = 1'b0;
      end else if ((exec_val_c & CMD_CGRAM_MASK) == CMD_CGRAM) begin
        cgram_d = 1'b1;
      end else if ((exec_val_c & CMD_FUNC_MASK) == CMD_FUNC) begin
        cgram_d = cgram_q;
      end else if ((exec_val_c & CMD_SHIFT_MASK) == CMD_SHIFT) begin
        if (!exec_val_c[3]) ac_d = ac_step(ac_q, exec_val_c[2]);
      end else if ((exec_val_c & CMD_DISP_MASK) == CMD_DISP) begin
        disp_d = exec_val_c[2];
      end else if ((exec_val_c & CMD_ENTRY_MASK) == CMD_ENTRY) begin
        id_d = exec_val_c[1];
      end else if ((exec_val_c & CMD_HOME_MASK) == CMD_HOME) begin
        ac_d = 7'h00;
      end else if (exec_val_c == CMD_CLEAR) begin
        chars_d = {32{SPACE}};
        ac_d    = 7'h00;
        id_d    = 1'b1;
      end
    end else if (exec_c && !exec_rw_c && !cgram_q) begin
      for (int i = 0; i < 32; i++) begin
        if (ac_visible(ac_q) && ac_char_idx(ac_q) == 5'(i)) chars_d[255-8*i -: 8] = exec_val_c;
      end
      ac_d = ac_step(ac_q, id_q);
    end else if (exec_c && exec_rw_c && exec_rs_c) begin
      ac_d = ac_step(ac_q, id_q);
    end
  end

`ifdef LCD_DEC_BUSY_EN
  // Busy countdown plus read-back nibble driven while a read holds lcd_e high.
  always_comb begin
    busy_d    = (busy_q != '0) ? busy_q - BUSY_W'(1) : busy_q;
    db_oe_d   = bus_e & bus_rw;
    rd_char_c = SPACE;
    for (int i = 0; i < 32; i++) begin
      if (ac_visible(ac_q) && ac_char_idx(ac_q) == 5'(i)) rd_char_c = chars_q[255-8*i -: 8];
    end
    if (!bus_rs) db_d = phase_lo ? ac_q[3:0] : {busy_q != '0, ac_q[6:4]};
    else         db_d = phase_lo ? rd_char_c[3:0] : rd_char_c[7:4];
    if (exec_c && !exec_rw_c) begin
      if (!exec_rs_c && (exec_val_c == CMD_CLEAR || (exec_val_c & CMD_HOME_MASK) == CMD_HOME))
        busy_d = BUSY_W'(CLEAR_CYCLES);
      else
        busy_d = BUSY_W'(BUSY_CYCLES);
    end
  end

  assign lcd_db_o  = db_q;
  assign lcd_db_oe = db_oe_q;
`endif

  assign chars      = chars_q;
  assign ac         = ac_q;
  assign display_on = disp_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder; the read-back test runs only with LCD_DEC_BUSY_EN.
module tb_lcd_bus_decoder;

  localparam int unsigned TB_BUSY  = 20;
  localparam int unsigned TB_CLEAR = 200;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [3:0]   nib = 4'h0;
  logic [255:0] chars;
  logic         display_on, four_bit, byte_stb, byte_rs;
  logic [6:0]   ac;
  logic [7:0]   byte_val;
`ifdef LCD_DEC_BUSY_EN
  logic [3:0]   lcd_db_o;
  logic         lcd_db_oe;
`endif

  int vec = 0;
  int miscompares = 0;
  int stb_cnt = 0;
  int stb_long = 0;
  logic stb_prev = 1'b0;
  logic [255:0] exp_chars;
  logic [255:0] all_space;

  lcd_bus_decoder #(.BUSY_CYCLES(TB_BUSY), .CLEAR_CYCLES(TB_CLEAR)) dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_4      (nib[0]),
    .lcd_5      (nib[1]),
    .lcd_6      (nib[2]),
    .lcd_7      (nib[3]),
    .chars      (chars),
    .display_on (display_on),
    .ac         (ac),
    .four_bit   (four_bit),
    .byte_stb   (byte_stb),
    .byte_rs    (byte_rs),
    .byte_val   (byte_val)
`ifdef LCD_DEC_BUSY_EN
    ,
    .lcd_db_o   (lcd_db_o),
    .lcd_db_oe  (lcd_db_oe)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_stb) stb_cnt <= stb_cnt + 1;
    if (byte_stb && stb_prev) stb_long <= stb_long + 1;
    stb_prev <= byte_stb;
  end

  task automatic pulse(input logic rs, input logic rw, input logic [3:0] n);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; nib = n; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] b);
    pulse(rs, rw, b[7:4]);
    pulse(rs, rw, b[3:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; nib = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_init();
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h2);
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (chars !== all_space) begin miscompares++; $display("FAIL reset_chars: got %h want %h", chars, all_space); end
    vec++; if (ac !== 7'h00) begin miscompares++; $display("FAIL reset_ac: got %h want 00", ac); end
    vec++; if ({display_on, four_bit, byte_stb, byte_rs} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {display_on, four_bit, byte_stb, byte_rs}); end
    vec++; if (byte_val !== 8'h00) begin miscompares++; $display("FAIL reset_byte_val: got %h want 00", byte_val); end
  endtask

  task automatic test_init();
    int c0;
    c0 = stb_cnt;
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    vec++; if (four_bit !== 1'b0) begin miscompares++; $display("FAIL init_3x: got four_bit=%b want 0", four_bit); end
    pulse(1'b0, 1'b0, 4'h2);
    vec++; if (four_bit !== 1'b1) begin miscompares++; $display("FAIL init_four_bit: got %b want 1", four_bit); end
    vec++; if (stb_cnt - c0 !== 0) begin miscompares++; $display("FAIL init_no_stb: got %0d pulses want 0", stb_cnt - c0); end
    vec++; if (chars !== all_space || display_on !== 1'b0) begin miscompares++; $display("FAIL init_display: got disp=%b chars=%h want 0, all space", display_on, chars); end
  endtask

  task automatic test_line1();
    int c0;
    c0 = stb_cnt;
    xfer(1'b0, 1'b0, 8'h0C);
    xfer(1'b0, 1'b0, 8'h80);
    xfer(1'b1, 1'b0, 8'h4D);
    xfer(1'b1, 1'b0, 8'h69);
    xfer(1'b1, 1'b0, 8'h6E);
    xfer(1'b1, 1'b0, 8'h68);
    vec++; if (display_on !== 1'b1) begin miscompares++; $display("FAIL line1_display_on: got %b want 1", display_on); end
    vec++; if (chars[255:224] !== 32'h4D696E68) begin miscompares++; $display("FAIL line1_text: got %h want 4d696e68", chars[255:224]); end
    vec++; if (ac !== 7'h04) begin miscompares++; $display("FAIL line1_ac: got %h want 04", ac); end
    vec++; if (byte_val !== 8'h68 || byte_rs !== 1'b1) begin miscompares++; $display("FAIL line1_last_byte: got rs=%b val=%h want 1 68", byte_rs, byte_val); end
    vec++; if (stb_cnt - c0 !== 6) begin miscompares++; $display("FAIL line1_stb_count: got %0d want 6", stb_cnt - c0); end
  endtask

  task automatic test_line2();
    xfer(1'b0, 1'b0, 8'hC0);
    xfer(1'b1, 1'b0, 8'h32);
    xfer(1'b1, 1'b0, 8'h30);
    xfer(1'b1, 1'b0, 8'h30);
    xfer(1'b1, 1'b0, 8'h33);
    vec++; if (chars[127:96] !== 32'h32303033) begin miscompares++; $display("FAIL line2_text: got %h want 32303033", chars[127:96]); end
    vec++; if (ac !== 7'h44) begin miscompares++; $display("FAIL line2_ac: got %h want 44", ac); end
  endtask

  task automatic test_wrap();
    exp_chars = all_space;
    exp_chars[255:224] = 32'h4D696E68;
    exp_chars[127:96]  = 32'h32303033;
    xfer(1'b0, 1'b0, 8'hA7);
    xfer(1'b1, 1'b0, 8'h41);
    vec++; if (chars !== exp_chars) begin miscompares++; $display("FAIL wrap_hidden_write: got %h want %h", chars, exp_chars); end
    vec++; if (ac !== 7'h40) begin miscompares++; $display("FAIL wrap_inc_ac: got %h want 40", ac); end
    xfer(1'b0, 1'b0, 8'h04);
    xfer(1'b1, 1'b0, 8'h42);
    exp_chars[127:120] = 8'h42;
    vec++; if (chars !== exp_chars) begin miscompares++; $display("FAIL wrap_char16: got %h want %h", chars, exp_chars); end
    vec++; if (ac !== 7'h27) begin miscompares++; $display("FAIL wrap_dec_ac: got %h want 27", ac); end
  endtask

  task automatic test_cursor_shift();
    xfer(1'b0, 1'b0, 8'h14);
    vec++; if (ac !== 7'h40) begin miscompares++; $display("FAIL shift_right: got %h want 40", ac); end
    xfer(1'b0, 1'b0, 8'h10);
    vec++; if (ac !== 7'h27) begin miscompares++; $display("FAIL shift_left: got %h want 27", ac); end
    xfer(1'b0, 1'b0, 8'h18);
    vec++; if (ac !== 7'h27) begin miscompares++; $display("FAIL display_shift_ignored: got %h want 27", ac); end
    xfer(1'b0, 1'b0, 8'h80);
    xfer(1'b0, 1'b0, 8'h10);
    vec++; if (ac !== 7'h67) begin miscompares++; $display("FAIL shift_wrap_down: got %h want 67", ac); end
    xfer(1'b0, 1'b0, 8'h14);
    vec++; if (ac !== 7'h00) begin miscompares++; $display("FAIL shift_wrap_up: got %h want 00", ac); end
  endtask

  task automatic test_reads();
    xfer(1'b0, 1'b0, 8'h06);
    xfer(1'b0, 1'b0, 8'h85);
    xfer(1'b1, 1'b1, 8'h00);
    vec++; if (ac !== 7'h06) begin miscompares++; $display("FAIL data_read_ac: got %h want 06", ac); end
    xfer(1'b0, 1'b1, 8'h00);
    vec++; if (ac !== 7'h06) begin miscompares++; $display("FAIL cmd_read_ac: got %h want 06", ac); end
    vec++; if (chars !== exp_chars) begin miscompares++; $display("FAIL read_chars: got %h want %h", chars, exp_chars); end
  endtask

  task automatic test_cgram();
    xfer(1'b0, 1'b0, 8'h40);
    xfer(1'b1, 1'b0, 8'h55);
    vec++; if (chars !== exp_chars || ac !== 7'h06) begin miscompares++; $display("FAIL cgram_discard: got ac=%h chars=%h want 06 %h", ac, chars, exp_chars); end
    xfer(1'b0, 1'b0, 8'h80);
    xfer(1'b1, 1'b0, 8'h58);
    exp_chars[255:248] = 8'h58;
    vec++; if (chars !== exp_chars || ac !== 7'h01) begin miscompares++; $display("FAIL ddram_after_cgram: got ac=%h chars=%h want 01 %h", ac, chars, exp_chars); end
  endtask

  task automatic test_rs_low_governs();
    xfer(1'b0, 1'b0, 8'h81);
    pulse(1'b0, 1'b0, 4'h4);
    pulse(1'b1, 1'b0, 4'h1);
    exp_chars[247:240] = 8'h41;
    vec++; if (chars !== exp_chars || byte_rs !== 1'b1 || byte_val !== 8'h41) begin miscompares++; $display("FAIL rs_low_nibble: got rs=%b val=%h chars=%h want 1 41 %h", byte_rs, byte_val, chars, exp_chars); end
    xfer(1'b0, 1'b0, 8'h08);
    vec++; if (display_on !== 1'b0) begin miscompares++; $display("FAIL display_off: got %b want 0", display_on); end
  endtask

  task automatic test_clear_timing();
    xfer(1'b0, 1'b0, 8'h04);
    pulse(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    nib = 4'h1; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    vec++; if (chars !== exp_chars || byte_stb !== 1'b0) begin miscompares++; $display("FAIL clear_early: got stb=%b chars=%h want 0 %h", byte_stb, chars, exp_chars); end
    @(negedge clk);
    vec++; if (chars !== all_space || ac !== 7'h00 || byte_stb !== 1'b1) begin miscompares++; $display("FAIL clear_edge_plus1: got stb=%b ac=%h chars=%h want 1 00 all space", byte_stb, ac, chars); end
    @(negedge clk);
    vec++; if (byte_stb !== 1'b0) begin miscompares++; $display("FAIL stb_one_cycle: got %b want 0", byte_stb); end
    repeat (2) @(negedge clk);
    xfer(1'b1, 1'b0, 8'h5A);
    vec++; if (chars[255:248] !== 8'h5A || ac !== 7'h01) begin miscompares++; $display("FAIL clear_sets_id: got ac=%h c0=%h want 01 5a", ac, chars[255:248]); end
  endtask

  task automatic test_reset_midbyte();
    int c0;
    pulse(1'b1, 1'b0, 4'h4);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec++; if (four_bit !== 1'b0 || chars !== all_space) begin miscompares++; $display("FAIL midbyte_reset: got four_bit=%b chars=%h want 0 all space", four_bit, chars); end
    c0 = stb_cnt;
    pulse(1'b1, 1'b0, 4'h4);
    vec++; if (stb_cnt - c0 !== 0 || four_bit !== 1'b0) begin miscompares++; $display("FAIL midbyte_back_in_init: got stb=%0d four_bit=%b want 0 0", stb_cnt - c0, four_bit); end
    pulse(1'b0, 1'b0, 4'h2);
    xfer(1'b1, 1'b0, 8'h4B);
    vec++; if (chars[255:248] !== 8'h4B || ac !== 7'h01) begin miscompares++; $display("FAIL midbyte_recover: got ac=%h c0=%h want 01 4b", ac, chars[255:248]); end
    vec++; if (stb_long !== 0) begin miscompares++; $display("FAIL stb_width: got %0d long pulses want 0", stb_long); end
  endtask

`ifdef LCD_DEC_BUSY_EN
  task automatic read_status(input string tag, input logic [3:0] want_hi, input logic [3:0] want_lo);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (lcd_db_oe !== 1'b1 || lcd_db_o !== want_hi) begin miscompares++; $display("FAIL %s_hi: got oe=%b db=%b want 1 %b", tag, lcd_db_oe, lcd_db_o, want_hi); end
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (lcd_db_oe !== 1'b0) begin miscompares++; $display("FAIL %s_oe_low: got %b want 0", tag, lcd_db_oe); end
    lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (lcd_db_o !== want_lo) begin miscompares++; $display("FAIL %s_lo: got %b want %b", tag, lcd_db_o, want_lo); end
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic test_busy();
    xfer(1'b0, 1'b0, 8'h01);
    read_status("busy_after_clear", 4'b1000, 4'b0000);
    repeat (TB_CLEAR + 10) @(negedge clk);
    read_status("idle_after_clear", 4'b0000, 4'b0000);
  endtask
`endif

  initial begin
    all_space = {32{8'h20}};
    exp_chars = all_space;
    test_reset();
    test_init();
    test_line1();
    test_line2();
    test_wrap();
    test_cursor_shift();
    test_reads();
    test_cgram();
    test_rs_low_governs();
    test_clear_timing();
    test_reset_midbyte();
`ifdef LCD_DEC_BUSY_EN
    test_busy();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
